// File: rtl/pulse_seq_gen_pkg.sv
// Shared types for the RF pulse sequencer: mode codes, FSM states, segment clamp.
// Optional abort support is enabled with PULSE_SEQ_ABORT_EN.
package pulse_seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_MZ     = 2'd0,
    MODE_RAMSEY = 2'd1,
    MODE_RABI   = 2'd2,
    MODE_RSV    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_P1,
    S_W1,
    S_P2,
    S_W2,
    S_P3,
    S_HOLD
  } state_e;

  localparam int unsigned LEN_W = 64;

  // A zero-length segment would never terminate, so it runs for one cycle.
  function automatic logic [LEN_W-1:0] seg_len(
    input logic [LEN_W-1:0] n
  );
    return (n == '0) ? LEN_W'(1) : n;
  endfunction

endpackage

// File: rtl/pulse_seq_gen_if.sv
// Control/status bundle between the trigger side and the pulse sequencer.
// The abort line exists only when PULSE_SEQ_ABORT_EN is defined.
interface pulse_seq_gen_if
  import pulse_seq_gen_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic             trig;
  logic [1:0]       mode;
  logic [CNT_W-1:0] wait_cyc;
  logic             rabi_clr;
`ifdef PULSE_SEQ_ABORT_EN
  logic             abort;
`endif
  logic             rf;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rabi_len;

  modport master (
`ifdef PULSE_SEQ_ABORT_EN
    output abort,
`endif
    output trig, mode, wait_cyc, rabi_clr,
    input  rf, busy, done, rabi_len
  );

  modport slave (
`ifdef PULSE_SEQ_ABORT_EN
    input  abort,
`endif
    input  trig, mode, wait_cyc, rabi_clr,
    output rf, busy, done, rabi_len
  );

endinterface

// File: rtl/pulse_seq_gen_trig_sync_edge.sv
// Two-flop synchroniser for the external trigger plus a rising-edge one-shot.
// Used by pulse_seq_gen (PULSE_SEQ_ABORT_EN does not affect this block).
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/pulse_seq_gen.sv
// RF pulse sequencer: Mach-Zehnder, Ramsey and Rabi-sweep shots on one gate line.
// Define PULSE_SEQ_ABORT_EN to add the abort input (forces HOLD mid-shot).
module pulse_seq_gen
  import pulse_seq_gen_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned START_CYC      = 400,
  parameter int unsigned PI_2_CYC       = 333,
  parameter int unsigned PI_CYC         = 666,
  parameter int unsigned END_CYC        = 33300,
  parameter int unsigned RABI_INIT      = 66,
  parameter int unsigned RABI_STEP      = 66,
  parameter int unsigned RABI_MAX_STEPS = 64
) (
  input logic            clk,
  input logic            rst,
  pulse_seq_gen_if.slave bus
);

  localparam logic [LEN_W-1:0] RABI_LAST_L =
    LEN_W'(RABI_INIT) +
    LEN_W'(RABI_STEP) * LEN_W'(RABI_MAX_STEPS - 1);

  localparam logic [CNT_W-1:0] R_INIT = CNT_W'(RABI_INIT);
  localparam logic [CNT_W-1:0] R_STEP = CNT_W'(RABI_STEP);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RABI_LAST_L);

  if (RABI_MAX_STEPS == 0 || CNT_W > LEN_W ||
      (CNT_W < LEN_W && (RABI_LAST_L >> CNT_W) != '0))
  begin : g_bad_param
    $error("pulse_seq_gen: Rabi sweep does not fit CNT_W");
  end

  state_e           state_q, state_d, nxt_seg;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] rabi_q, rabi_d;
  logic             rf_q, rf_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;
  logic             start;
  logic [LEN_W-1:0] cur_len;
  logic             seg_end;

  trig_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.trig),
    .rise_o (start)
  );

  always_comb begin
    cur_len = LEN_W'(1);
    unique case (state_q)
      S_START: cur_len = seg_len(LEN_W'(START_CYC));
      S_P1: cur_len = seg_len((mode_q == MODE_RABI) ?
                              LEN_W'(rabi_q) :
                              LEN_W'(PI_2_CYC));
      S_W1,
      S_W2:    cur_len = seg_len(LEN_W'(wait_q));
      S_P2:    cur_len = seg_len(LEN_W'(PI_CYC));
      S_P3:    cur_len = seg_len(LEN_W'(PI_2_CYC));
      S_HOLD:  cur_len = seg_len(LEN_W'(END_CYC));
      default: cur_len = LEN_W'(1);
    endcase
  end

  assign seg_end = (LEN_W'(cnt_q) == cur_len - LEN_W'(1));

  always_comb begin
    nxt_seg = S_IDLE;
    unique case (state_q)
      S_START: nxt_seg = S_P1;
      S_P1:    nxt_seg = (mode_q == MODE_RABI) ? S_HOLD : S_W1;
      S_W1:    nxt_seg = (mode_q == MODE_MZ) ? S_P2 : S_P3;
      S_P2:    nxt_seg = S_W2;
      S_W2:    nxt_seg = S_P3;
      S_P3:    nxt_seg = S_HOLD;
      default: nxt_seg = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    mode_d  = mode_q;
    wait_d  = wait_q;
    rabi_d  = rabi_q;
    done_d  = 1'b0;
    abrt_d  = abrt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (bus.rabi_clr) rabi_d = R_INIT;
      if (start && bus.mode != MODE_RSV) begin
        state_d = S_START;
        mode_d  = mode_e'(bus.mode);
        wait_d  = bus.wait_cyc;
        abrt_d  = 1'b0;
      end
    end else if (seg_end) begin
      cnt_d   = '0;
      state_d = nxt_seg;
      if (state_q == S_HOLD) begin
        done_d = 1'b1;
        if (mode_q == MODE_RABI && !abrt_q)
          rabi_d = (rabi_q == R_LAST) ? R_INIT : rabi_q + R_STEP;
      end
    end
`ifdef PULSE_SEQ_ABORT_EN
    if (bus.abort && state_q != S_IDLE && state_q != S_HOLD) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      abrt_d  = 1'b1;
    end
`endif
    rf_d = (state_d == S_P1) || (state_d == S_P2) ||
           (state_d == S_P3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_MZ;
      cnt_q   <= '0;
      wait_q  <= '0;
      rabi_q  <= R_INIT;
      rf_q    <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rabi_q  <= rabi_d;
      rf_q    <= rf_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign bus.rf       = rf_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.rabi_len = rabi_q;

endmodule
